// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial receive path: FSM encoding and the
// common 9600-baud timing constants used by serial_rx and its neighbours.
package serial_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // 50 MHz / 9600 baud
    localparam int CLKS_PER_BIT_9600 = 5208;
    localparam int CNT_W             = 13;

endpackage

// File: rtl/serial_rx_sync2.sv
// Two-flop synchroniser for an asynchronous input; resets to 1 so an idle
// serial line or released button reads as inactive.
module serial_rx_sync2 (
    input  logic sysclk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/serial_rx.sv
// 8N1 asynchronous receiver: mid-bit sampling, one-cycle valid strobe and
// one-cycle framing-error strobe; a held-low line parks in BREAK.
//
//  state | meaning
//  IDLE  | line idle, waiting for a low sample
//  START | timing to mid start bit, rejecting glitches
//  DATA  | sampling 8 data bits LSB first
//  STOP  | sampling the stop bit
//  BREAK | stop bit was low; wait for the line to return high
module serial_rx #(
    parameter int CLKS_PER_BIT = serial_rx_pkg::CLKS_PER_BIT_9600,
    parameter int CNT_W        = serial_rx_pkg::CNT_W
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);
    import serial_rx_pkg::*;

    localparam int             HALF    = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitn_q, bitn_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;

    serial_rx_sync2 u_sync (
        .sysclk (sysclk),
        .reset  (reset),
        .d      (serial_in),
        .q      (rx_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bitn_d  = bitn_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        bitn_d  = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == LAST) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = '0;
                    bitn_d  = bitn_q + 3'd1;
                    if (bitn_q == 3'd7) state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bitn_q  <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
Standalone 8N1 asynchronous serial receiver. It is the receive-side counterpart to the `cereal` transmitter, at the same 9600 baud on the 50 MHz `sysclk`. It replaces ad-hoc bit sampling in top-level blocks with a clean byte stream carrying a one-cycle `valid` strobe and a framing-error flag. Consumers (e.g. a character store feeding RAM) latch `data` on `valid`.

Parameters:
- CLKS_PER_BIT, 5208, `sysclk` cycles per serial bit (50 MHz / 9600). Must be ≥ 4.
- CNT_W, 13, bit-counter width. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- sysclk  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- serial_in  input  1  asynchronous serial line; idle high
- data  output  8  last correctly framed byte, LSB = first data bit received
- valid  output  1  one-cycle strobe: `data` updated this cycle
- frame_err  output  1  one-cycle strobe: stop bit sampled low
- busy  output  1  high while in any state other than IDLE

Behaviour:
- Clocking and reset: single clock `sysclk`; reset is synchronous, active-high.
- Reset values:
  - `data` = 0, `valid` = 0, `frame_err` = 0, `busy` = 0
  - state = IDLE, counters = 0
  - both synchroniser flops = 1 (idle line)
- Synchroniser: two-flop on `serial_in`. Its output `rx_s` is the only line sample used by the FSM.
- HALF = CLKS_PER_BIT/2 (integer division). `cnt` counts 0..CLKS_PER_BIT-1. `bitn` is 3 bits.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: if `rx_s`==0, go to START with `cnt`=0.
  - START: `cnt` increments each cycle. At `cnt`==HALF-1, check `rx_s`:
    - `rx_s`==0: go to DATA with `cnt`=0, `bitn`=0.
    - `rx_s`==1: glitch; return to IDLE with no strobe.
  - DATA: at `cnt`==CLKS_PER_BIT-1:
    - shift register takes `rx_s` into bit 7 and shifts right (LSB-first);
    - `cnt`=0, `bitn`++;
    - when `bitn`==7 at that point, go to STOP.
  - STOP: at `cnt`==CLKS_PER_BIT-1:
    - `rx_s`==1: `data` <= shift register, `valid`=1 for one cycle, go to IDLE;
    - `rx_s`==0: `data` unchanged, `frame_err`=1 for one cycle, go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. No new start is detected while the line is held low.
- Sampling: every sample lands at mid-bit.
- Latency: `valid` is high on the edge 3 + HALF + 9*CLKS_PER_BIT cycles after the falling edge of the start bit at the pin. This includes 2 synchroniser cycles and 1 IDLE decision cycle.
- Back-to-back bytes: the stop-bit sample occurs mid stop bit, so IDLE is re-entered half a bit before the next start edge. Zero-gap frames are received without loss.
- `valid` and `frame_err` are never high in the same cycle.
- `data` holds its value until the next `valid`.
- Reset mid-frame: the partial byte is discarded, no strobe is generated, and the block is in IDLE on the following cycle.
- Line stuck low after reset: IDLE → START → DATA → STOP, then `frame_err`, then BREAK until the line returns high.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=0, START=1, DATA=2, STOP=3, BREAK=4 (3 bits);
  - the defaults CLKS_PER_BIT_9600 = 5208 and CNT_W = 13, so `cereal`, `clockdiv` instances and `serial_rx` share one baud constant.
- Natural sub-module: `sync2`, a parameterless two-flop synchroniser reset to 1. It is reusable for the button inputs ahead of `debouncer`.

Test Plan (CLKS_PER_BIT = 16, HALF = 8; frames driven with an ideal 16-cycle bit period):
1. Byte 0x41 ('A'), 8N1 → `valid` pulses exactly once, 155 cycles after the start edge; `data`=0x41; `frame_err` stays 0.
2. Two zero-gap frames 0x08 then 0xFF → two `valid` pulses 160 cycles apart; `data`=0x08, then `data`=0xFF.
3. 5-cycle low glitch on an idle line → no `valid`, no `frame_err`; `busy` high for ≤ 11 cycles, then IDLE.
4. Frame 0x55 with stop bit driven 0, line held low 64 further cycles → `frame_err` pulses once; `data` keeps its previous value; `busy` stays high until 3 cycles after the line returns high. A following 0x33 frame is received correctly.
5. `reset` asserted for 1 cycle during data bit 4 of 0x7E → no strobe, `busy`=0 the next cycle. A following 0x31 frame yields `data`=0x31.
6. After reset with the line idle → `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0 for 100 cycles.
